// File: rtl/bsg_front_side_bus_hop_in.sv
// rtl/bsg_front_side_bus_hop_in.sv - front-side bus hop ingress: two-entry FIFO with per-packet local/forward/broadcast steering
module bsg_front_side_bus_hop_in #(
  parameter int width_p     = 16,
  parameter int id_width_p  = 4,
  parameter int len_width_p = 4,
  parameter int local_id_p  = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic [1:0]         v_o,
  output logic [width_p-1:0] data_o,
  input  logic [1:0]         ready_i
);

  localparam logic [id_width_p-1:0] local_id_lp = id_width_p'(local_id_p);
  localparam logic [id_width_p-1:0] bcast_id_lp = {id_width_p{1'b1}};

  typedef enum logic {
    e_hdr = 1'b0,
    e_pay = 1'b1
  } state_e;

  // input FIFO storage; words are only ever read from the registered head
  logic [width_p-1:0] mem_r [2];
  logic               wr_ptr_r;
  logic               rd_ptr_r;
  logic [1:0]         count_r;

  logic               full;
  logic               fifo_valid;
  logic               enq;
  logic               deq;

  state_e                 state_r, state_n;
  logic [len_width_p-1:0] cnt_r, cnt_n;
  logic [1:0]             route_r, route_n;
  logic [1:0]             sent_r, sent_n;

  logic [id_width_p-1:0]  dest;
  logic [len_width_p-1:0] len;
  logic [1:0]             hdr_route;
  logic [1:0]             route;
  logic [1:0]             take;
  logic [1:0]             done;

  assign full       = (count_r == 2'd2);
  assign fifo_valid = (count_r != 2'd0);
  assign ready_o    = ~full & ~reset_i;
  assign enq        = v_i & ready_o;

  assign data_o = mem_r[rd_ptr_r];
  assign dest   = data_o[id_width_p-1:0];
  assign len    = data_o[id_width_p+len_width_p-1:id_width_p];

  always_comb begin
    hdr_route = 2'b01;
    if (dest == local_id_lp)
      hdr_route = 2'b10;
    else if (dest == bcast_id_lp)
      hdr_route = 2'b11;
  end

  assign route = (state_r == e_hdr) ? hdr_route : route_r;

  // a port that already took the head word is masked until the word leaves
  assign v_o  = {2{fifo_valid}} & route & ~sent_r;
  assign take = v_o & ready_i;
  assign done = ~route | sent_r | take;
  assign deq  = fifo_valid & done[0] & done[1];

  always_ff @(posedge clk_i) begin
    if (enq)
      mem_r[wr_ptr_r] <= data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (enq)
        wr_ptr_r <= ~wr_ptr_r;
      if (deq)
        rd_ptr_r <= ~rd_ptr_r;
      count_r <= count_r + 2'(enq) - 2'(deq);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_hdr;
      cnt_r   <= '0;
      route_r <= 2'b00;
      sent_r  <= 2'b00;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      route_r <= route_n;
      sent_r  <= sent_n;
    end
  end

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    route_n = route_r;
    sent_n  = deq ? 2'b00 : (sent_r | take);
    if (deq) begin
      case (state_r)
        e_hdr: begin
          route_n = hdr_route;
          cnt_n   = len;
          if (len != '0)
            state_n = e_pay;
        end
        e_pay: begin
          cnt_n = cnt_r - len_width_p'(1);
          if (cnt_r == len_width_p'(1))
            state_n = e_hdr;
        end
        default: state_n = e_hdr;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_front_side_bus_hop_in.sv
// tb/tb_bsg_front_side_bus_hop_in.sv - self-checking bench for bsg_front_side_bus_hop_in
module tb_bsg_front_side_bus_hop_in;

  logic        clk_i;
  logic        reset_i;
  logic        v_i;
  logic [15:0] data_i;
  logic        ready_o;
  logic [1:0]  v_o;
  logic [15:0] data_o;
  logic [1:0]  ready_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] in_q[$];
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  bsg_front_side_bus_hop_in #(
    .width_p(16), .id_width_p(4), .len_width_p(4), .local_id_p(3)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .ready_i(ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // table entry: {v_i, data_i, ready_i, exp ready_o, exp v_o, exp data_o}
  task automatic run_table(input string name, input logic [37:0] t [], input int n);
    for (int c = 0; c < n; c++) begin
      v_i     = t[c][37];
      data_i  = t[c][36:21];
      ready_i = t[c][20:19];
      @(negedge clk_i);
      n_checks++;
      if (ready_o !== t[c][18]) begin
        n_fail++;
        $display("FAIL %s ready_o cyc %0d: got %b exp %b", name, c, ready_o, t[c][18]);
      end
      n_checks++;
      if (v_o !== t[c][17:16]) begin
        n_fail++;
        $display("FAIL %s v_o cyc %0d: got %b exp %b", name, c, v_o, t[c][17:16]);
      end
      if (t[c][17:16] != 2'b00) begin
        n_checks++;
        if (data_o !== t[c][15:0]) begin
          n_fail++;
          $display("FAIL %s data_o cyc %0d: got %h exp %h", name, c, data_o, t[c][15:0]);
        end
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; v_i = 1'b0; data_i = '0; ready_i = 2'b00;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++;
    if (v_o !== 2'b00 || ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: v_o=%b ready_o=%b exp 00/0", v_o, ready_o);
    end
    reset_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (v_o !== 2'b00 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle: v_o=%b ready_o=%b exp 00/1", v_o, ready_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_local();
    logic [37:0] t [] = '{
      {1'b1, 16'h0023, 2'b11, 1'b1, 2'b00, 16'h0000},
      {1'b1, 16'hAAAA, 2'b11, 1'b1, 2'b10, 16'h0023},
      {1'b1, 16'hBBBB, 2'b11, 1'b1, 2'b10, 16'hAAAA},
      {1'b0, 16'h0000, 2'b11, 1'b1, 2'b10, 16'hBBBB},
      {1'b0, 16'h0000, 2'b11, 1'b1, 2'b00, 16'h0000}};
    run_table("local", t, 5);
  endtask

  task automatic test_forward_zero_len();
    logic [37:0] t [] = '{
      {1'b1, 16'h0005, 2'b11, 1'b1, 2'b00, 16'h0000},
      {1'b1, 16'h0013, 2'b11, 1'b1, 2'b01, 16'h0005},
      {1'b1, 16'h1234, 2'b11, 1'b1, 2'b10, 16'h0013},
      {1'b0, 16'h0000, 2'b11, 1'b1, 2'b10, 16'h1234},
      {1'b0, 16'h0000, 2'b11, 1'b1, 2'b00, 16'h0000}};
    run_table("fwd0", t, 5);
  endtask

  task automatic test_broadcast_staggered();
    logic [37:0] t [] = '{
      {1'b1, 16'h001F, 2'b01, 1'b1, 2'b00, 16'h0000},
      {1'b1, 16'hCAFE, 2'b01, 1'b1, 2'b11, 16'h001F},
      {1'b0, 16'h0000, 2'b10, 1'b0, 2'b10, 16'h001F},
      {1'b0, 16'h0000, 2'b11, 1'b1, 2'b11, 16'hCAFE},
      {1'b0, 16'h0000, 2'b11, 1'b1, 2'b00, 16'h0000}};
    run_table("bcast", t, 5);
  endtask

  task automatic test_back_to_back();
    logic [37:0] t [] = '{
      {1'b1, 16'h0035, 2'b00, 1'b1, 2'b00, 16'h0000},
      {1'b1, 16'h1111, 2'b00, 1'b1, 2'b01, 16'h0035},
      {1'b1, 16'h2222, 2'b00, 1'b0, 2'b01, 16'h0035},
      {1'b1, 16'h2222, 2'b11, 1'b0, 2'b01, 16'h0035},
      {1'b1, 16'h2222, 2'b11, 1'b1, 2'b01, 16'h1111},
      {1'b1, 16'h3333, 2'b11, 1'b1, 2'b01, 16'h2222},
      {1'b0, 16'h0000, 2'b11, 1'b1, 2'b01, 16'h3333},
      {1'b0, 16'h0000, 2'b11, 1'b1, 2'b00, 16'h0000}};
    run_table("full", t, 8);
  endtask

  task automatic test_reset_mid_packet();
    logic [37:0] t [] = '{
      {1'b1, 16'h0023, 2'b11, 1'b1, 2'b00, 16'h0000},
      {1'b1, 16'hAAAA, 2'b11, 1'b1, 2'b10, 16'h0023},
      {1'b1, 16'hBBBB, 2'b11, 1'b1, 2'b10, 16'hAAAA},
      {1'b0, 16'h0000, 2'b11, 1'b1, 2'b10, 16'hBBBB},
      {1'b0, 16'h0000, 2'b11, 1'b1, 2'b00, 16'h0000}};
    logic [15:0] words [4] = '{16'h00F5, 16'h1001, 16'h1002, 16'h1003};
    ready_i = 2'b11;
    for (int c = 0; c < 4; c++) begin
      v_i = 1'b1; data_i = words[c];
      @(posedge clk_i); #1;
    end
    v_i = 1'b0;
    #1;
    n_checks++;
    if (v_o !== 2'b01 || data_o !== 16'h1003) begin
      n_fail++;
      $display("FAIL midpkt_before: v_o=%b data_o=%h exp 01/1003", v_o, data_o);
    end
    reset_i = 1'b1;
    #1;
    n_checks++;
    if (v_o !== 2'b00 || ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midpkt_async: v_o=%b ready_o=%b exp 00/0", v_o, ready_o);
    end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    run_table("after_rst", t, 5);
  endtask

  task automatic test_random();
    int          cyc = 0;
    logic [3:0]  dest;
    logic [3:0]  len;
    logic [15:0] hdr;
    logic [15:0] w;
    logic [15:0] exp;
    logic [1:0]  vsave;
    for (int p = 0; p < 40; p++) begin
      case ($urandom_range(0, 3))
        0:       dest = 4'd3;
        1:       dest = 4'hF;
        default: dest = 4'($urandom_range(0, 14));
      endcase
      len = (p == 0) ? 4'hF : 4'($urandom_range(0, 15));
      hdr = {8'($urandom), len, dest};
      in_q.push_back(hdr);
      if (dest == 4'd3 || dest == 4'hF) exp_q1.push_back(hdr);
      if (dest != 4'd3)                 exp_q0.push_back(hdr);
      for (int i = 0; i < int'(len); i++) begin
        w = 16'($urandom);
        in_q.push_back(w);
        if (dest == 4'd3 || dest == 4'hF) exp_q1.push_back(w);
        if (dest != 4'd3)                 exp_q0.push_back(w);
      end
    end
    while ((in_q.size() > 0 || exp_q0.size() > 0 || exp_q1.size() > 0) && cyc < 20000) begin
      v_i     = (in_q.size() > 0) && ($urandom_range(0, 3) != 0);
      data_i  = (in_q.size() > 0) ? in_q[0] : 16'($urandom);
      ready_i = 2'($urandom_range(0, 3));
      @(negedge clk_i);
      vsave = v_o;
      ready_i = ~ready_i;
      #1;
      n_checks++;
      if (v_o !== vsave) begin
        n_fail++;
        $display("FAIL rand_v_o_vs_ready cyc %0d: got %b exp %b", cyc, v_o, vsave);
      end
      ready_i = ~ready_i;
      #1;
      if (v_o[0] && ready_i[0]) begin
        n_checks++;
        if (exp_q0.size() == 0) begin
          n_fail++;
          $display("FAIL rand_fwd_extra cyc %0d: got %h exp none", cyc, data_o);
        end else begin
          exp = exp_q0.pop_front();
          if (data_o !== exp) begin
            n_fail++;
            $display("FAIL rand_fwd_data cyc %0d: got %h exp %h", cyc, data_o, exp);
          end
        end
      end
      if (v_o[1] && ready_i[1]) begin
        n_checks++;
        if (exp_q1.size() == 0) begin
          n_fail++;
          $display("FAIL rand_local_extra cyc %0d: got %h exp none", cyc, data_o);
        end else begin
          exp = exp_q1.pop_front();
          if (data_o !== exp) begin
            n_fail++;
            $display("FAIL rand_local_data cyc %0d: got %h exp %h", cyc, data_o, exp);
          end
        end
      end
      if (v_i && ready_o) void'(in_q.pop_front());
      @(posedge clk_i); #1;
      cyc++;
    end
    v_i = 1'b0;
    n_checks++;
    if (cyc >= 20000) begin
      n_fail++;
      $display("FAIL rand_timeout: left in=%0d fwd=%0d local=%0d exp 0", in_q.size(), exp_q0.size(), exp_q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_local();
    test_forward_zero_len();
    test_broadcast_staggered();
    test_back_to_back();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
